// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - IF-stage PC, instruction memory handshake and IF/ID register
// Optional build macro FETCH_PERF_COUNTERS_EN adds fetch_count/bubble_count outputs.
module instruction_fetch_controller #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              imem_ready,
  input  logic [31:0]       imem_instruction,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instruction_out,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0]       fetch_count,
  output logic [31:0]       bubble_count,
`endif
  output logic              valid_out
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] buf_pc;
  logic [31:0]       buf_instr;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] branch_target;
  logic              fetch_hit;

  // Word-align the branch target; the low two bits never reach the PC.
  assign branch_target = branch_address & ~ADDR_W'(3);
  assign pc_next       = pc + FOUR;
  assign imem_req      = (state == FETCH) && !rst;
  assign imem_addr     = pc;
  assign fetch_hit     = (state == FETCH) && imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      buf_pc          <= '0;
      buf_instr       <= '0;
      pc_out          <= '0;
      instruction_out <= '0;
      valid_out       <= 1'b0;
    end else if (branch_taken) begin
      state           <= FETCH;
      pc              <= branch_target;
      buf_pc          <= '0;
      buf_instr       <= '0;
      pc_out          <= '0;
      instruction_out <= '0;
      valid_out       <= 1'b0;
    end else if (freeze) begin
      // A word returned while frozen is parked so it is neither lost nor refetched.
      if (fetch_hit) begin
        buf_pc    <= pc_next;
        buf_instr <= imem_instruction;
        pc        <= pc_next;
        state     <= HOLD;
      end
    end else if (state == HOLD) begin
      pc_out          <= buf_pc;
      instruction_out <= buf_instr;
      valid_out       <= 1'b1;
      state           <= FETCH;
    end else if (imem_ready) begin
      pc_out          <= pc_next;
      instruction_out <= imem_instruction;
      valid_out       <= 1'b1;
      pc              <= pc_next;
    end else begin
      valid_out <= 1'b0;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else if (branch_taken) begin
      bubble_count <= bubble_count + 32'd1;
    end else if (!freeze) begin
      if (state == HOLD || imem_ready)
        fetch_count <= fetch_count + 32'd1;
      else
        bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - scoreboard bench for instruction_fetch_controller
module tb_instruction_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_instruction;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
  } ifid_t;
  ifid_t sb[$];
  ifid_t e;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hE3A00014;
      32'h4:   return 32'hE3A01A01;
      32'hC:   return 32'hE0923002;
      default: return 32'hA5000000 ^ a;
    endcase
  endfunction

  // Memory model: combinational read of whatever address is presented.
  assign imem_instruction = word(imem_addr);

  instruction_fetch_controller #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_ready(imem_ready),
    .imem_instruction(imem_instruction), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc_out(pc_out), .instruction_out(instruction_out),
`ifdef FETCH_PERF_COUNTERS_EN
    .fetch_count(fetch_count), .bubble_count(bubble_count),
`endif
    .valid_out(valid_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests++;
    if ({valid_out, pc_out, instruction_out, imem_addr, imem_req} !== 98'b0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%0b pc=%h ins=%h addr=%h req=%0b, expected all 0",
               valid_out, pc_out, instruction_out, imem_addr, imem_req);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_first_req: got req=%0b addr=%h, expected req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{1'b1, 32'(4 * (k + 1)), word(32'(4 * k))});
      tick();
      e = sb.pop_front();
      tests++;
      if (valid_out !== e.v || pc_out !== e.pc || instruction_out !== e.ins) begin
        fails++;
        $display("FAIL seq_%0d: got v=%0b pc=%h ins=%h, expected v=%0b pc=%h ins=%h",
                 k, valid_out, pc_out, instruction_out, e.v, e.pc, e.ins);
      end
    end
    tests++;
    if (imem_addr !== 32'hC) begin
      fails++;
      $display("FAIL seq_addr: got %h expected 0000000c", imem_addr);
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{1'b1, 32'hC, word(32'h8)});
      tick();
      e = sb.pop_front();
      tests++;
      if (valid_out !== e.v || pc_out !== e.pc || instruction_out !== e.ins || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL freeze_hold_%0d: got v=%0b pc=%h ins=%h req=%0b, expected v=%0b pc=%h ins=%h req=0",
                 k, valid_out, pc_out, instruction_out, imem_req, e.v, e.pc, e.ins);
      end
    end
    freeze = 1'b0;
    sb.push_back('{1'b1, 32'h10, 32'hE0923002});
    tick();
    e = sb.pop_front();
    tests++;
    if (valid_out !== e.v || pc_out !== e.pc || instruction_out !== e.ins
        || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      fails++;
      $display("FAIL freeze_release: got v=%0b pc=%h ins=%h req=%0b addr=%h, expected v=1 pc=%h ins=%h req=1 addr=00000010",
               valid_out, pc_out, instruction_out, imem_req, imem_addr, e.pc, e.ins);
    end
    sb.push_back('{1'b1, 32'h14, word(32'h10)});
    tick();
    e = sb.pop_front();
    tests++;
    if (valid_out !== e.v || pc_out !== e.pc || instruction_out !== e.ins) begin
      fails++;
      $display("FAIL freeze_after: got v=%0b pc=%h ins=%h, expected v=1 pc=%h ins=%h",
               valid_out, pc_out, instruction_out, e.pc, e.ins);
    end
  endtask

  task automatic test_not_ready();
    imem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++;
      if (valid_out !== 1'b0 || imem_addr !== 32'h14 || imem_req !== 1'b1) begin
        fails++;
        $display("FAIL not_ready_%0d: got v=%0b addr=%h req=%0b, expected v=0 addr=00000014 req=1",
                 k, valid_out, imem_addr, imem_req);
      end
    end
    imem_ready = 1'b1;
    sb.push_back('{1'b1, 32'h18, word(32'h14)});
    tick();
    e = sb.pop_front();
    tests++;
    if (valid_out !== e.v || pc_out !== e.pc || instruction_out !== e.ins) begin
      fails++;
      $display("FAIL not_ready_resume: got v=%0b pc=%h ins=%h, expected v=1 pc=%h ins=%h",
               valid_out, pc_out, instruction_out, e.pc, e.ins);
    end
  endtask

  task automatic test_branch(input logic [31:0] target, input logic [31:0] aligned, input string name);
    branch_taken   = 1'b1;
    branch_address = target;
    sb.push_back('{1'b0, 32'h0, 32'h0});
    tick();
    e = sb.pop_front();
    branch_taken = 1'b0;
    freeze       = 1'b0;
    tests++;
    if (valid_out !== e.v || pc_out !== e.pc || instruction_out !== e.ins
        || imem_addr !== aligned || imem_req !== 1'b1) begin
      fails++;
      $display("FAIL %s_flush: got v=%0b pc=%h ins=%h addr=%h req=%0b, expected v=0 pc=0 ins=0 addr=%h req=1",
               name, valid_out, pc_out, instruction_out, imem_addr, imem_req, aligned);
    end
    sb.push_back('{1'b1, aligned + 32'd4, word(aligned)});
    tick();
    e = sb.pop_front();
    tests++;
    if (valid_out !== e.v || pc_out !== e.pc || instruction_out !== e.ins || imem_addr !== aligned + 32'd4) begin
      fails++;
      $display("FAIL %s_target: got v=%0b pc=%h ins=%h addr=%h, expected v=1 pc=%h ins=%h addr=%h",
               name, valid_out, pc_out, instruction_out, imem_addr, e.pc, e.ins, aligned + 32'd4);
    end
  endtask

  task automatic test_branch_cases();
    freeze = 1'b1;
    test_branch(32'h43, 32'h40, "branch_freeze");
    freeze = 1'b1;
    tick();
    test_branch(32'h100, 32'h100, "branch_from_hold");
    test_branch(32'hFFFFFFFC, 32'hFFFFFFFC, "wrap");
  endtask

  task automatic test_reset_hold();
    freeze = 1'b1;
    tick();
    tests++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL hold_entry: got req=%0b expected 0", imem_req);
    end
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({valid_out, pc_out, instruction_out, imem_addr, imem_req} !== 98'b0) begin
      fails++;
      $display("FAIL async_reset: got v=%0b pc=%h ins=%h addr=%h req=%0b, expected all 0",
               valid_out, pc_out, instruction_out, imem_addr, imem_req);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    tests++;
    if (fetch_count !== 32'h0 || bubble_count !== 32'h0) begin
      fails++;
      $display("FAIL counters_reset: got fetch=%0d bubble=%0d, expected 0 0", fetch_count, bubble_count);
    end
`endif
    #1 rst = 1'b0;
    freeze = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1) begin
      fails++;
      $display("FAIL reset_leaves_hold: got req=%0b expected 1", imem_req);
    end
    sb.push_back('{1'b1, 32'h4, word(32'h0)});
    tick();
    e = sb.pop_front();
    tests++;
    if (valid_out !== e.v || pc_out !== e.pc || instruction_out !== e.ins) begin
      fails++;
      $display("FAIL post_reset_fetch: got v=%0b pc=%h ins=%h, expected v=1 pc=%h ins=%h",
               valid_out, pc_out, instruction_out, e.pc, e.ins);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_freeze();
    test_not_ready();
    test_branch_cases();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_controller.md
Name: instruction_fetch_controller

Overview:
- Sequences the instruction memory for the ARM IF stage.
- Owns the PC register and drives the request/address handshake to the instruction memory.
- Holds an instruction returned while the pipeline is frozen in a one-entry buffer.
- Loads the IF/ID pipeline register; applies branch redirect/flush from EXE and freeze from the hazard unit.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 0, PC value after reset; multiple of 4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- freeze  input  1  hazard stall; IF/ID and PC must not advance.
- branch_taken  input  1  EXE branch; redirect PC and flush IF/ID.
- branch_address  input  ADDR_W  branch target.
- imem_ready  input  1  memory has valid data for the current request; may be high the same cycle as imem_req.
- imem_instruction  input  32  instruction word for imem_addr; sampled only when imem_req && imem_ready.
- imem_req  output  1  fetch request, combinational from state.
- imem_addr  output  ADDR_W  fetch address; equals the PC register.
- pc_out  output  ADDR_W  IF/ID register: address of fetched instruction + 4.
- instruction_out  output  32  IF/ID register: instruction word.
- valid_out  output  1  IF/ID register holds a real instruction; 0 means bubble.

Behaviour:
- Reset, asynchronous on rst high:
  - pc = RESET_PC; state = FETCH; hold buffer cleared.
  - pc_out = 0; instruction_out = 0; valid_out = 0.
  - First request appears the cycle after rst deasserts.
- States:
  - FETCH: imem_req = 1.
  - HOLD: imem_req = 0; a frozen fetch result is buffered.
- imem_addr = pc in both states; branch_address[1:0] is forced to 00 when loaded.
- Priority each cycle: branch_taken > freeze > normal advance.
- branch_taken = 1, any state, freeze ignored:
  - pc <= {branch_address[ADDR_W-1:2], 2'b00}; state <= FETCH.
  - valid_out <= 0, with pc_out and instruction_out cleared to 0.
  - Hold buffer and any same-cycle memory data are discarded.
- freeze = 1, no branch:
  - IF/ID registers unchanged.
  - FETCH with imem_ready: buffer <= {pc+4, imem_instruction}; pc <= pc+4; state <= HOLD.
  - FETCH without imem_ready: pc unchanged; request stays asserted.
  - HOLD: nothing changes.
- Normal advance, freeze = 0 and no branch:
  - FETCH with imem_ready: IF/ID <= {pc+4, imem_instruction, 1}; pc <= pc+4.
  - FETCH without imem_ready: valid_out <= 0 (bubble); pc unchanged.
  - HOLD: IF/ID <= {buffer, 1}; state <= FETCH; no request that cycle.
- Latency and throughput:
  - Fetch-to-IF/ID is one clock.
  - With imem_ready tied high, sustains one instruction per cycle.
  - A freeze released from HOLD costs one request-free cycle.
- Arithmetic: pc+4 is modulo 2^ADDR_W; 0xFFFFFFFC + 4 wraps to 0 with no error.
- Ordering guarantees: no instruction is lost or duplicated across freeze; each address is delivered to IF/ID exactly once unless flushed.
- Mid-operation: rst during HOLD or during an unanswered request aborts it; no stale buffer data survives.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs fetch_count[31:0] and bubble_count[31:0], both reset to 0 and wrapping at 2^32.
  - fetch_count increments on each cycle valid_out is loaded with 1.
  - bubble_count increments on each cycle valid_out is loaded with 0 by a flush or a not-ready bubble.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then imem_ready = 1, memory returns 0xE3A00014 at 0 and 0xE3A01A01 at 4:
  - Cycle 1: valid_out = 1, pc_out = 4, instruction_out = 0xE3A00014.
  - Cycle 2: pc_out = 8, instruction_out = 0xE3A01A01.
- freeze high 3 cycles while fetching address 12 (0xE0923002):
  - IF/ID holds the prior instruction; imem_req drops after one cycle.
  - After release, IF/ID = {16, 0xE0923002}; next request is at address 16.
- branch_taken with branch_address = 0x43, plus freeze high, in the same cycle:
  - Next cycle: valid_out = 0, imem_addr = 0x40.
  - Following cycle: IF/ID = {0x44, word at 0x40}.
- imem_ready low for 2 cycles at address 20:
  - valid_out = 0 for 2 cycles; imem_addr stays 20.
  - Then IF/ID = {24, word at 20}.
- pc = 0xFFFFFFFC with ready: IF/ID pc_out = 0 and the next imem_addr = 0.
- rst asserted asynchronously mid-cycle while in HOLD:
  - All outputs go to 0 immediately; state = FETCH; imem_addr = RESET_PC.
  - With the macro defined, both counters read 0.
